snn_run_sequencer: RTL and testbench
====================================

Name: snn_run_sequencer

Overview:
- Controller in front of the two-layer delayed SNN core.
- Loads the core's wide configuration (weights, delays, threshold, decay, refractory period) through a byte-wide valid/ready port.
- Runs a programmed number of timesteps by sequencing the core's enable and delay_clk strobes.
- Counts output spikes per output neuron and reports done.

Parameters:
- W_BYTES, 208: weight bytes (1664 bits).
- D_BYTES, 104: delay bytes (832 bits).
- N_OUT, 2: output neurons counted.
- SETTLE, 2: idle cycles between the enable strobe and the delay_clk strobe (legal range 1-15).

Ports:
- clk, input, 1: single clock.
- reset, input, 1: asynchronous reset, active-high.
- cfg_clear, input, 1: one-cycle pulse. Sets the load pointer to 0 and clears cfg_loaded.
- cfg_valid, input, 1: config byte valid.
- cfg_data, input, 8: config byte.
- cfg_ready, output, 1: config byte accepted on a cycle where cfg_valid and cfg_ready are both 1.
- cfg_loaded, output, 1: all config bytes received.
- start, input, 1: run request, sampled in IDLE only.
- num_steps, input, 8: timesteps per run, latched on start.
- busy, output, 1: run in progress.
- done, output, 1: one-cycle pulse at end of run.
- start_err, output, 1: sticky; set by start while not loaded. Cleared by cfg_clear.
- net_enable, output, 1: enable strobe to the core.
- net_delay_clk, output, 1: delay-clock strobe to the core.
- weights, output, 8*W_BYTES: config image.
- delays, output, 8*D_BYTES: config image.
- threshold, output, 8: config image.
- decay, output, 8: config image.
- refractory_period, output, 8: config image.
- net_spikes, input, N_OUT: core output spikes.
- spike_count, output, 8*N_OUT: per-neuron spike counts. Neuron i occupies bits [8i+7:8i].

Behaviour:
- Reset values:
  - All config registers 0; load pointer 0.
  - cfg_loaded = 0, start_err = 0.
  - busy, done, net_enable, net_delay_clk = 0.
  - spike_count = 0; FSM in IDLE.
- Config load:
  - Byte address mapping:
    - Addresses 0..W_BYTES-1 go to weights[8a+:8].
    - The next D_BYTES addresses go to delays[8(a-W_BYTES)+:8].
    - Then threshold, then decay, then refractory_period.
    - Total CFG_BYTES = W_BYTES + D_BYTES + 3.
  - The pointer increments on each accepted byte.
  - On acceptance of byte CFG_BYTES-1, cfg_loaded rises on the next cycle.
  - cfg_ready = !busy && !cfg_loaded. Bytes offered after the load completes are not accepted; no wrap.
  - cfg_clear has priority over a same-cycle byte: the byte is dropped and the pointer goes to 0.
  - cfg_clear while busy is ignored.
  - Config registers hold their values across cfg_clear; they are overwritten only by new bytes.
- FSM states: IDLE, EN, SETTLE, DCLK, GAP, FIN.
  - IDLE:
    - start && cfg_loaded && num_steps != 0: latch num_steps, clear spike_count, go to EN.
    - start && cfg_loaded && num_steps == 0: go straight to FIN (done pulse, counts cleared).
    - start && !cfg_loaded: set start_err, stay in IDLE.
  - EN: net_enable = 1 for exactly one cycle, then SETTLE.
  - SETTLE: wait SETTLE cycles, then DCLK.
  - DCLK: net_delay_clk = 1 for one cycle, then GAP.
  - GAP: one low cycle. Decrement the step counter. If the counter reaches 0, go to FIN; otherwise go to EN.
  - FIN: done = 1 for one cycle, then IDLE.
- busy is 1 in every state except IDLE. It is combinational from the state register, so it is 1 in the cycle after start is accepted.
- Cycles per timestep = SETTLE + 3. Start-to-done latency = num_steps*(SETTLE+3) + 1 cycles, with done asserted in the final of those cycles.
- Spike counting:
  - Active only while busy and not in FIN.
  - Each cycle that net_spikes[i] = 1 increments count i.
  - Counts saturate at 255.
  - Counts hold after done until the next accepted start.
- start while busy is ignored.
- Reset mid-run returns every output to its reset value immediately, including the config image. After reset, a full reload is required.

Test Plan:
- Load 315 bytes with value = address mod 256 -> weights[7:0] = 0x00, weights[1663:1656] = 0xCF, delays[7:0] = 0xD0, threshold = 0x38, decay = 0x39, refractory_period = 0x3A, cfg_loaded = 1, cfg_ready = 0.
- start with num_steps = 3, SETTLE = 2 -> exactly three net_enable pulses 5 cycles apart. Each net_delay_clk pulse follows its enable by 3 cycles. done is high 16 cycles after start. busy is low afterwards.
- start before loading completes (100 bytes sent) -> start_err = 1, no enable pulses. cfg_clear then clears start_err and sets the pointer to 0.
- net_spikes = 2'b01 held high for a 100-step run -> spike_count[7:0] = 255 (saturated), spike_count[15:8] = 0.
- Assert reset in SETTLE of step 2 -> all outputs 0 on the same cycle, cfg_loaded = 0. start afterwards sets start_err.
- cfg_clear and cfg_valid in the same cycle, then 315 bytes -> the first byte is dropped, loading restarts at address 0, and the image matches the new stream.

Source files
------------

// File: rtl/snn_run_sequencer.sv
// Run controller for the two-layer delayed SNN core: byte-wide config loader,
// timestep strobe sequencer and saturating per-neuron output spike counters.
module snn_run_sequencer #(
   parameter int unsigned W_BYTES = 208,
   parameter int unsigned D_BYTES = 104,
   parameter int unsigned N_OUT   = 2,
   parameter int unsigned SETTLE  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_clear,
   input  logic                   cfg_valid,
   input  logic [7:0]             cfg_data,
   output logic                   cfg_ready,
   output logic                   cfg_loaded,
   input  logic                   start,
   input  logic [7:0]             num_steps,
   output logic                   busy,
   output logic                   done,
   output logic                   start_err,
   output logic                   net_enable,
   output logic                   net_delay_clk,
   output logic [8*W_BYTES-1:0]   weights,
   output logic [8*D_BYTES-1:0]   delays,
   output logic [7:0]             threshold,
   output logic [7:0]             decay,
   output logic [7:0]             refractory_period,
   input  logic [N_OUT-1:0]       net_spikes,
   output logic [8*N_OUT-1:0]     spike_count
);

   localparam int unsigned CFG_BYTES = W_BYTES + D_BYTES + 3;
   localparam int unsigned PTR_W     = $clog2(CFG_BYTES);
   localparam int unsigned WI_W      = $clog2(8 * W_BYTES);
   localparam int unsigned DI_W      = $clog2(8 * D_BYTES);

   typedef enum logic [2:0] {
      ST_IDLE, ST_EN, ST_SETTLE, ST_DCLK, ST_GAP, ST_FIN
   } state_t;

   state_t           state;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] d_idx;
   logic [WI_W-1:0]  w_off;
   logic [DI_W-1:0]  d_off;
   logic [7:0]       step_cnt;
   logic [3:0]       settle_cnt;

   assign busy      = (state != ST_IDLE);
   assign cfg_ready = !busy && !cfg_loaded;

   // Bit offsets of the current load pointer inside the weight and delay images.
   always_comb begin
      d_idx = ptr - PTR_W'(W_BYTES);
      w_off = WI_W'(ptr) << 3;
      d_off = DI_W'(d_idx) << 3;
   end

   // Config image loader; a clear wins over a same-cycle byte and is ignored mid-run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr               <= '0;
         cfg_loaded        <= 1'b0;
         start_err         <= 1'b0;
         weights           <= '0;
         delays            <= '0;
         threshold         <= 8'd0;
         decay             <= 8'd0;
         refractory_period <= 8'd0;
      end else begin
         if (cfg_clear && !busy) begin
            ptr        <= '0;
            cfg_loaded <= 1'b0;
            start_err  <= 1'b0;
         end else begin
            if (cfg_valid && cfg_ready) begin
               if (ptr < PTR_W'(W_BYTES))
                  weights[w_off +: 8] <= cfg_data;
               else if (ptr < PTR_W'(W_BYTES + D_BYTES))
                  delays[d_off +: 8] <= cfg_data;
               else if (ptr == PTR_W'(W_BYTES + D_BYTES))
                  threshold <= cfg_data;
               else if (ptr == PTR_W'(W_BYTES + D_BYTES + 1))
                  decay <= cfg_data;
               else
                  refractory_period <= cfg_data;
               ptr <= ptr + PTR_W'(1);
               if (ptr == PTR_W'(CFG_BYTES - 1))
                  cfg_loaded <= 1'b1;
            end
            if (state == ST_IDLE && start && !cfg_loaded)
               start_err <= 1'b1;
         end
      end
   end

   // Timestep sequencer with registered strobes, plus the spike counters it gates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         step_cnt      <= 8'd0;
         settle_cnt    <= 4'd0;
         net_enable    <= 1'b0;
         net_delay_clk <= 1'b0;
         done          <= 1'b0;
         spike_count   <= '0;
      end else begin
         net_enable    <= 1'b0;
         net_delay_clk <= 1'b0;
         done          <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && cfg_loaded) begin
                  spike_count <= '0;
                  if (num_steps != 8'd0) begin
                     step_cnt   <= num_steps;
                     net_enable <= 1'b1;
                     state      <= ST_EN;
                  end else begin
                     done  <= 1'b1;
                     state <= ST_FIN;
                  end
               end
            end
            ST_EN: begin
               settle_cnt <= 4'd0;
               state      <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settle_cnt == 4'(SETTLE - 1)) begin
                  net_delay_clk <= 1'b1;
                  state         <= ST_DCLK;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            ST_DCLK: state <= ST_GAP;
            ST_GAP: begin
               step_cnt <= step_cnt - 8'd1;
               if (step_cnt == 8'd1) begin
                  done  <= 1'b1;
                  state <= ST_FIN;
               end else begin
                  net_enable <= 1'b1;
                  state      <= ST_EN;
               end
            end
            ST_FIN:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase

         if (busy && state != ST_FIN) begin
            for (int i = 0; i < int'(N_OUT); i++) begin
               if (net_spikes[i] && spike_count[8*i +: 8] != 8'hFF)
                  spike_count[8*i +: 8] <= spike_count[8*i +: 8] + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_snn_run_sequencer.sv
// Self-checking bench for snn_run_sequencer: strobe/done timing is scoreboarded
// through expected-cycle queues, config image and spike counts against a bench model.
module tb_snn_run_sequencer;

   localparam int W_BYTES   = 208;
   localparam int D_BYTES   = 104;
   localparam int N_OUT     = 2;
   localparam int SETTLE    = 2;
   localparam int CFG_BYTES = W_BYTES + D_BYTES + 3;
   localparam int STEP_CYC  = SETTLE + 3;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 cfg_clear, cfg_valid, start;
   logic [7:0]           cfg_data, num_steps;
   logic                 cfg_ready, cfg_loaded, busy, done, start_err;
   logic                 net_enable, net_delay_clk;
   logic [8*W_BYTES-1:0] weights;
   logic [8*D_BYTES-1:0] delays;
   logic [7:0]           threshold, decay, refractory_period;
   logic [N_OUT-1:0]     net_spikes;
   logic [8*N_OUT-1:0]   spike_count;

   int n_pass = 0;
   int n_chk  = 0;
   int cyc    = 0;
   int en_q[$];
   int dc_q[$];
   int done_q[$];

   snn_run_sequencer #(.W_BYTES(W_BYTES), .D_BYTES(D_BYTES), .N_OUT(N_OUT), .SETTLE(SETTLE)) dut (
      .clk(clk), .reset(reset), .cfg_clear(cfg_clear), .cfg_valid(cfg_valid),
      .cfg_data(cfg_data), .cfg_ready(cfg_ready), .cfg_loaded(cfg_loaded),
      .start(start), .num_steps(num_steps), .busy(busy), .done(done),
      .start_err(start_err), .net_enable(net_enable), .net_delay_clk(net_delay_clk),
      .weights(weights), .delays(delays), .threshold(threshold), .decay(decay),
      .refractory_period(refractory_period), .net_spikes(net_spikes),
      .spike_count(spike_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Strobe monitor: every pulse must match the next expected cycle in its queue.
   always @(negedge clk) begin
      if (!reset) begin
         if (net_enable) begin
            if (en_q.size() == 0) chk("en_extra", 32'd1, 32'd0);
            else chk("en_cyc", cyc, en_q.pop_front());
         end
         if (net_delay_clk) begin
            if (dc_q.size() == 0) chk("dclk_extra", 32'd1, 32'd0);
            else chk("dclk_cyc", cyc, dc_q.pop_front());
         end
         if (done) begin
            if (done_q.size() == 0) chk("done_extra", 32'd1, 32'd0);
            else chk("done_cyc", cyc, done_q.pop_front());
         end
      end
   end

   function automatic logic [7:0] exp_byte(input int a, input int base);
      return 8'((a + base) % 256);
   endfunction

   function automatic logic [7:0] dut_byte(input int a);
      if (a < W_BYTES)                return weights[8*a +: 8];
      else if (a < W_BYTES + D_BYTES) return delays[8*(a - W_BYTES) +: 8];
      else if (a == W_BYTES + D_BYTES) return threshold;
      else if (a == W_BYTES + D_BYTES + 1) return decay;
      else                             return refractory_period;
   endfunction

   task automatic load_bytes(input int n, input int base);
      for (int a = 0; a < n; a++) begin
         @(negedge clk);
         cfg_clear = 1'b0;
         cfg_valid = 1'b1;
         cfg_data  = exp_byte(a, base);
         if (!cfg_ready) begin
            chk("load_ready", 32'(cfg_ready), 32'd1);
            break;
         end
      end
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic check_image(input int base);
      for (int a = 0; a < CFG_BYTES; a++)
         chk($sformatf("img[%0d]", a), 32'(dut_byte(a)), 32'(exp_byte(a, base)));
      chk("cfg_loaded", 32'(cfg_loaded), 32'd1);
      chk("cfg_ready_full", 32'(cfg_ready), 32'd0);
   endtask

   task automatic try_unloaded_start(input string tag);
      @(negedge clk);
      start = 1'b1;
      num_steps = 8'd3;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_err"}, 32'(start_err), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      repeat (20) @(negedge clk);
   endtask

   // One run of n steps; also pokes an ignored start and cfg_clear while busy.
   task automatic run(input int n, input bit hold01);
      int k;
      int exp0, exp1;
      logic [1:0] sp;
      @(negedge clk);
      k = cyc;
      start = 1'b1;
      num_steps = 8'(n);
      for (int j = 0; j < n; j++) begin
         en_q.push_back(k + 1 + STEP_CYC * j);
         dc_q.push_back(k + 1 + SETTLE + 1 + STEP_CYC * j);
      end
      done_q.push_back(k + 1 + STEP_CYC * n);
      exp0 = 0;
      exp1 = 0;
      net_spikes = hold01 ? 2'b01 : 2'($urandom);
      for (int c = 1; c <= STEP_CYC * n + 3; c++) begin
         @(negedge clk);
         start     = (c == 3 && n > 0);
         num_steps = start ? 8'd7 : 8'(n);
         cfg_clear = (c == 2 && n > 0);
         sp = hold01 ? 2'b01 : 2'($urandom);
         net_spikes = sp;
         if (c <= STEP_CYC * n) begin
            if (sp[0] && exp0 < 255) exp0++;
            if (sp[1] && exp1 < 255) exp1++;
         end
      end
      start = 1'b0;
      cfg_clear = 1'b0;
      net_spikes = 2'b00;
      chk($sformatf("cnt0_n%0d", n), 32'(spike_count[7:0]), 32'(exp0));
      chk($sformatf("cnt1_n%0d", n), 32'(spike_count[15:8]), 32'(exp1));
      chk("busy_after", 32'(busy), 32'd0);
      chk("loaded_kept", 32'(cfg_loaded), 32'd1);
      chk("en_left", 32'(en_q.size()), 32'd0);
      chk("dclk_left", 32'(dc_q.size()), 32'd0);
      chk("done_left", 32'(done_q.size()), 32'd0);
   endtask

   initial begin
      int k;
      reset = 1'b1;
      cfg_clear = 1'b0; cfg_valid = 1'b0; cfg_data = 8'd0;
      start = 1'b0; num_steps = 8'd0; net_spikes = 2'b00;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_loaded", 32'(cfg_loaded), 32'd0);
      chk("rst_err", 32'(start_err), 32'd0);
      chk("rst_en", 32'(net_enable), 32'd0);
      chk("rst_dclk", 32'(net_delay_clk), 32'd0);
      chk("rst_cnt", 32'(spike_count), 32'd0);
      chk("rst_thr", 32'(threshold), 32'd0);
      reset = 1'b0;

      // Start before load completes, then clear.
      load_bytes(100, 1);
      chk("part_loaded", 32'(cfg_loaded), 32'd0);
      try_unloaded_start("early");
      cfg_clear = 1'b1;
      @(negedge clk);
      cfg_clear = 1'b0;
      chk("clr_err", 32'(start_err), 32'd0);
      chk("clr_hold_w0", 32'(weights[7:0]), 32'h01);

      // Full load restarts at address 0.
      load_bytes(CFG_BYTES, 0);
      check_image(0);
      chk("w_lo", 32'(weights[7:0]), 32'h00);
      chk("w_hi", 32'(weights[1663:1656]), 32'hCF);
      chk("d_lo", 32'(delays[7:0]), 32'hD0);
      chk("thr", 32'(threshold), 32'h38);
      chk("decay", 32'(decay), 32'h39);
      chk("refr", 32'(refractory_period), 32'h3A);
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_data = 8'hAA;
      repeat (2) @(negedge clk);
      cfg_valid = 1'b0;
      chk("extra_refr", 32'(refractory_period), 32'h3A);
      chk("extra_w0", 32'(weights[7:0]), 32'h00);

      run(3, 1'b0);
      run(0, 1'b0);
      run(100, 1'b1);
      run(2, 1'b0);

      // Reset during SETTLE of step 2.
      @(negedge clk);
      k = cyc;
      start = 1'b1;
      num_steps = 8'd3;
      net_spikes = 2'b11;
      en_q.push_back(k + 1);
      en_q.push_back(k + 1 + STEP_CYC);
      dc_q.push_back(k + 1 + SETTLE + 1);
      for (int c = 1; c <= STEP_CYC + 2; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("pre_rst_busy", 32'(busy), 32'd1);
      chk("pre_rst_en_q", 32'(en_q.size()), 32'd0);
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_en", 32'(net_enable), 32'd0);
      chk("mid_rst_dclk", 32'(net_delay_clk), 32'd0);
      chk("mid_rst_loaded", 32'(cfg_loaded), 32'd0);
      chk("mid_rst_cnt", 32'(spike_count), 32'd0);
      chk("mid_rst_thr", 32'(threshold), 32'd0);
      chk("mid_rst_w_hi", 32'(weights[1663:1656]), 32'd0);
      chk("mid_rst_d_lo", 32'(delays[7:0]), 32'd0);
      chk("mid_rst_refr", 32'(refractory_period), 32'd0);
      en_q.delete();
      dc_q.delete();
      done_q.delete();
      net_spikes = 2'b00;
      @(negedge clk);
      reset = 1'b0;
      try_unloaded_start("post_rst");

      // Clear with a same-cycle byte mid-load, then a fresh stream.
      load_bytes(10, 9);
      @(negedge clk);
      cfg_clear = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = 8'h77;
      load_bytes(CFG_BYTES, 5);
      cfg_clear = 1'b0;
      check_image(5);
      chk("clr_err2", 32'(start_err), 32'd0);
      run(1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
